// File: rtl/queue_pkg.sv
// Shared constants for the queue read-side path.
// Occupancy codes are used by the pop skid buffer and its users.
package queue_pkg;

  localparam int DATA_WIDTH    = 64;
  localparam int ADDRESS_WIDTH = 3;
  localparam int SKID_DEPTH    = 2;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

endpackage

// File: rtl/pop_skid_buf.sv
// Two-entry head/tail skid register pair with occupancy counter.
// The head entry always drives rd_data.
module pop_skid_buf
  import queue_pkg::*;
#(
  parameter int DW = DATA_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic [1:0]    occ
);

  logic [DW-1:0] head_q, head_d;
  logic [DW-1:0] tail_q, tail_d;
  logic [1:0]    occ_q, occ_d;
  logic          pop;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    pop    = rd_en && (occ_q != OCC_EMPTY);
    unique case (occ_q)
      OCC_EMPTY: begin
        if (wr_en) head_d = wr_data;
      end
      OCC_ONE: begin
        if (wr_en) begin
          if (pop) head_d = wr_data;
          else     tail_d = wr_data;
        end
      end
      OCC_FULL: begin
        // Popping from full promotes tail; a new word refills tail.
        if (pop) begin
          head_d = tail_q;
          if (wr_en) tail_d = wr_data;
        end
      end
      default: ;
    endcase
    occ_d = occ_q + {1'b0, wr_en} - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= OCC_EMPTY;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign rd_data = head_q;
  assign occ     = occ_q;

  ap_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(wr_en && !pop && occ_q == OCC_FULL)
  );

endmodule

// File: rtl/queue_pop_ctrl.sv
// Queue read-side controller: issues pops, absorbs the read
// latency in a 2-entry skid and streams words out valid/ready.
module queue_pop_ctrl #(
  parameter int DATA_WIDTH    = queue_pkg::DATA_WIDTH,
  parameter int ADDRESS_WIDTH = queue_pkg::ADDRESS_WIDTH,
  parameter int SKID_DEPTH    = queue_pkg::SKID_DEPTH
) (
  input  logic                     sclk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     q_empty,
  input  logic [DATA_WIDTH-1:0]    q_data_out,
  output logic                     q_read_en,
  output logic                     m_valid,
  output logic [DATA_WIDTH-1:0]    m_data,
  input  logic                     m_ready,
  output logic [ADDRESS_WIDTH+1:0] pop_count,
  output logic                     busy
);

  localparam int PCW = ADDRESS_WIDTH + 2;

  if (SKID_DEPTH != queue_pkg::SKID_DEPTH) begin : g_bad_depth
    $error("queue_pop_ctrl: SKID_DEPTH must be 2");
  end

  logic           inflight_q, inflight_d;
  logic [PCW-1:0] pop_count_q, pop_count_d;
  logic [1:0]     occ;
  logic           accept;
  logic [2:0]     held;

  assign m_valid = (occ != queue_pkg::OCC_EMPTY);
  assign accept  = m_valid && m_ready;

  always_comb begin
    // Words owned after this edge if no new read is issued.
    held = {1'b0, occ}
         + {2'b00, inflight_q}
         - {2'b00, accept};
    q_read_en   = enable && !q_empty
               && (held < 3'd2);
    inflight_d  = q_read_en;
    pop_count_d = pop_count_q
                + {{(PCW-1){1'b0}}, accept};
  end

  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      inflight_q  <= 1'b0;
      pop_count_q <= '0;
    end else begin
      inflight_q  <= inflight_d;
      pop_count_q <= pop_count_d;
    end
  end

  pop_skid_buf #(
    .DW (DATA_WIDTH)
  ) u_skid (
    .clk     (sclk),
    .rst_n   (reset_n),
    .wr_en   (inflight_q),
    .wr_data (q_data_out),
    .rd_en   (accept),
    .rd_data (m_data),
    .occ     (occ)
  );

  assign pop_count = pop_count_q;
  assign busy      = m_valid || inflight_q;

endmodule

// File: tb/tb_queue_pop_ctrl.sv
// Bench for queue_pop_ctrl: behavioural queue, order scoreboard,
// per-scenario tasks plus a randomized stress pass.
module tb_queue_pop_ctrl;

  localparam int DW  = 64;
  localparam int AW  = 3;
  localparam int PCW = AW + 2;
  localparam int QD  = 1 << AW;

  logic           sclk = 1'b0;
  logic           reset_n = 1'b0;
  logic           enable = 1'b0;
  logic           q_empty = 1'b1;
  logic [DW-1:0]  q_data_out = '0;
  logic           m_ready = 1'b0;
  logic           push = 1'b0;
  logic [DW-1:0]  push_data = '0;
  logic           q_read_en;
  logic           m_valid;
  logic [DW-1:0]  m_data;
  logic [PCW-1:0] pop_count;
  logic           busy;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] fifo[$];
  logic [DW-1:0] exp_q[$];
  int            model_cnt = 0;
  int            outstanding = 0;
  bit            prev_hold = 0;
  logic [DW-1:0] prev_data = '0;

  always #5 sclk = ~sclk;

  queue_pop_ctrl #(
    .DATA_WIDTH    (DW),
    .ADDRESS_WIDTH (AW),
    .SKID_DEPTH    (2)
  ) dut (
    .sclk       (sclk),
    .reset_n    (reset_n),
    .enable     (enable),
    .q_empty    (q_empty),
    .q_data_out (q_data_out),
    .q_read_en  (q_read_en),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .pop_count  (pop_count),
    .busy       (busy)
  );

  // Synchronous queue: 1-cycle read latency, shares reset_n.
  always @(posedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      fifo.delete();
      exp_q.delete();
      q_data_out <= '0;
      q_empty    <= 1'b1;
    end else begin
      if (q_read_en && fifo.size() > 0)
        q_data_out <= fifo.pop_front();
      if (push && fifo.size() < QD) begin
        fifo.push_back(push_data);
        exp_q.push_back(push_data);
      end
      q_empty <= (fifo.size() == 0);
    end
  end

  // Stream scoreboard: order, hold-stability, count, occupancy.
  always @(negedge sclk) begin
    logic [DW-1:0] e;
    int nxt;
    bit acc;
    if (!reset_n) begin
      model_cnt   = 0;
      outstanding = 0;
      prev_hold   = 0;
    end else begin
      acc = m_valid && m_ready;
      checks++;
      if (q_read_en && q_empty) begin
        errors++;
        $display("FAIL rd_on_empty: q_read_en=1 want 0");
      end
      checks++;
      if (busy !== (outstanding != 0)) begin
        errors++;
        $display("FAIL busy: got %0b want %0b",
                 busy, outstanding != 0);
      end
      checks++;
      if (pop_count !== PCW'(model_cnt)) begin
        errors++;
        $display("FAIL pop_count: got %0d want %0d",
                 pop_count, PCW'(model_cnt));
      end
      if (prev_hold) begin
        checks++;
        if (!m_valid || m_data !== prev_data) begin
          errors++;
          $display("FAIL hold: v=%0b d=%0h want v=1 d=%0h",
                   m_valid, m_data, prev_data);
        end
      end
      if (acc) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL order: got %0h want none", m_data);
        end else begin
          e = exp_q.pop_front();
          if (m_data !== e) begin
            errors++;
            $display("FAIL order: got %0h want %0h", m_data, e);
          end
        end
        model_cnt++;
      end
      nxt = outstanding + int'(q_read_en) - int'(acc);
      checks++;
      if (nxt > 2) begin
        errors++;
        $display("FAIL occ: got %0d want <=2", nxt);
      end
      outstanding = nxt;
      prev_hold   = m_valid && !m_ready;
      prev_data   = m_data;
    end
  end

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    push      = 1'b1;
    push_data = d;
    tick();
    push      = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    enable  = 1'b0;
    m_ready = 1'b0;
    repeat (2) @(posedge sclk);
    #1;
    checks += 5;
    if (q_read_en !== 1'b0) begin
      errors++;
      $display("FAIL rst_rd: got %0b want 0", q_read_en);
    end
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid: got %0b want 0", m_valid);
    end
    if (m_data !== '0) begin
      errors++;
      $display("FAIL rst_data: got %0h want 0", m_data);
    end
    if (pop_count !== '0) begin
      errors++;
      $display("FAIL rst_cnt: got %0d want 0", pop_count);
    end
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy: got %0b want 0", busy);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_stream();
    logic [DW-1:0] d[4];
    logic [DW-1:0] got[16];
    int  acyc[16];
    bit  bsy[20];
    int  reads = 0, n = 0, f = -1, l = -1;
    int  cnt0 = model_cnt;
    d = '{64'd1, 64'd256, 64'd3325, 64'd0};
    enable  = 1'b1;
    m_ready = 1'b1;
    fork
      for (int i = 0; i < 4; i++) push_word(d[i]);
      for (int c = 0; c < 16; c++) begin
        @(negedge sclk);
        if (q_read_en) begin
          reads++;
          if (f < 0) f = c;
          l = c;
        end
        if (m_valid && m_ready) begin
          got[n]  = m_data;
          acyc[n] = c;
          n++;
        end
        bsy[c] = busy;
      end
    join
    checks += 3;
    if (reads != 4 || l - f != 3) begin
      errors++;
      $display("FAIL s1_reads: got %0d span %0d want 4 span 3",
               reads, l - f);
    end
    if (n != 4 || acyc[3] - acyc[0] != 3) begin
      errors++;
      $display("FAIL s1_accepts: got %0d want 4 consecutive", n);
    end
    if (pop_count !== PCW'(cnt0 + 4)) begin
      errors++;
      $display("FAIL s1_cnt: got %0d want %0d",
               pop_count, PCW'(cnt0 + 4));
    end
    for (int i = 0; i < 4 && i < n; i++) begin
      checks++;
      if (got[i] !== d[i]) begin
        errors++;
        $display("FAIL s1_data%0d: got %0h want %0h",
                 i, got[i], d[i]);
      end
    end
    if (n == 4 && acyc[3] < 15) begin
      checks++;
      if (!bsy[acyc[3]] || bsy[acyc[3] + 1]) begin
        errors++;
        $display("FAIL s1_busy_fall: got %0b%0b want 10",
                 bsy[acyc[3]], bsy[acyc[3] + 1]);
      end
    end
    tick();
  endtask

  task automatic test_fill_stall();
    logic [DW-1:0] got[16];
    int acyc[16];
    int reads = 0, n = 0;
    int cnt0 = model_cnt;
    m_ready = 1'b0;
    enable  = 1'b1;
    fork
      for (int i = 0; i < 8; i++) push_word(DW'(i));
      for (int c = 0; c < 14; c++) begin
        @(negedge sclk);
        if (q_read_en) reads++;
      end
    join
    checks += 2;
    if (reads != 2) begin
      errors++;
      $display("FAIL s2_reads: got %0d want 2", reads);
    end
    if (!busy || !m_valid) begin
      errors++;
      $display("FAIL s2_full: busy=%0b v=%0b want 1 1",
               busy, m_valid);
    end
    repeat (3) begin
      @(negedge sclk);
      checks++;
      if (m_data !== '0) begin
        errors++;
        $display("FAIL s2_hold: got %0h want 0", m_data);
      end
    end
    tick();
    m_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(negedge sclk);
      if (m_valid && m_ready) begin
        got[n]  = m_data;
        acyc[n] = c;
        n++;
      end
    end
    checks += 2;
    if (n != 8 || acyc[7] - acyc[0] != 7) begin
      errors++;
      $display("FAIL s2_drain: got %0d want 8 gapless", n);
    end
    if (pop_count !== PCW'(cnt0 + 8)) begin
      errors++;
      $display("FAIL s2_cnt: got %0d want %0d",
               pop_count, PCW'(cnt0 + 8));
    end
    for (int i = 0; i < 8 && i < n; i++) begin
      checks++;
      if (got[i] !== DW'(i)) begin
        errors++;
        $display("FAIL s2_data%0d: got %0h want %0h",
                 i, got[i], i);
      end
    end
    tick();
  endtask

  task automatic test_toggle();
    logic [DW-1:0] got[16];
    int n = 0, mx = 0;
    int cnt0 = model_cnt;
    m_ready = 1'b0;
    enable  = 1'b1;
    for (int i = 0; i < 8; i++) push_word(DW'(i));
    for (int c = 0; c < 40; c++) begin
      m_ready = (c % 2 == 0);
      @(negedge sclk);
      if (outstanding > mx) mx = outstanding;
      if (m_valid && m_ready && n < 16) begin
        got[n] = m_data;
        n++;
      end
      tick();
    end
    m_ready = 1'b1;
    checks += 3;
    if (n != 8) begin
      errors++;
      $display("FAIL s3_count: got %0d want 8", n);
    end
    if (mx > 2) begin
      errors++;
      $display("FAIL s3_occ: got %0d want <=2", mx);
    end
    if (pop_count !== PCW'(cnt0 + 8)) begin
      errors++;
      $display("FAIL s3_cnt: got %0d want %0d",
               pop_count, PCW'(cnt0 + 8));
    end
    for (int i = 0; i < 8 && i < n; i++) begin
      checks++;
      if (got[i] !== DW'(i)) begin
        errors++;
        $display("FAIL s3_data%0d: got %0h want %0h",
                 i, got[i], i);
      end
    end
  endtask

  task automatic test_empty();
    int rd = 0, first = -1;
    logic [DW-1:0] d0 = '0;
    m_ready = 1'b0;
    enable  = 1'b1;
    repeat (10) begin
      @(negedge sclk);
      if (q_read_en) rd++;
    end
    tick();
    checks++;
    if (rd != 0) begin
      errors++;
      $display("FAIL s4_idle_rd: got %0d want 0", rd);
    end
    push_word(64'hA5);
    for (int k = 0; k < 6; k++) begin
      @(negedge sclk);
      if (m_valid && first < 0) begin
        first = k;
        d0    = m_data;
      end
    end
    checks += 2;
    if (first != 2) begin
      errors++;
      $display("FAIL s4_latency: got %0d want 2", first);
    end
    if (d0 !== 64'hA5) begin
      errors++;
      $display("FAIL s4_data: got %0h want a5", d0);
    end
    tick();
    m_ready = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_enable_gate();
    logic [DW-1:0] got[8];
    int rd = 0, n = 0;
    enable  = 1'b0;
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_word(DW'(8'h51 + i));
    repeat (2) tick();
    enable = 1'b1;
    @(negedge sclk);
    checks++;
    if (q_read_en !== 1'b1) begin
      errors++;
      $display("FAIL s5_read: got %0b want 1", q_read_en);
    end
    tick();
    enable  = 1'b0;
    m_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge sclk);
      if (q_read_en) rd++;
      if (m_valid && m_ready && n < 8) begin
        got[n] = m_data;
        n++;
      end
    end
    checks += 2;
    if (rd != 0) begin
      errors++;
      $display("FAIL s5_gated: got %0d reads want 0", rd);
    end
    if (n != 1 || got[0] !== 64'h51) begin
      errors++;
      $display("FAIL s5_inflight: got n=%0d d=%0h want 1 51",
               n, got[0]);
    end
    tick();
    enable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge sclk);
      if (m_valid && m_ready && n < 8) begin
        got[n] = m_data;
        n++;
      end
    end
    checks++;
    if (n != 3 || got[1] !== 64'h52 || got[2] !== 64'h53) begin
      errors++;
      $display("FAIL s5_resume: got n=%0d want 3 (51 52 53)", n);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    logic [DW-1:0] d0 = '0;
    enable  = 1'b1;
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(DW'(8'h70 + i));
    repeat (3) tick();
    checks++;
    if (!(busy && m_valid && outstanding == 2)) begin
      errors++;
      $display("FAIL s6_pre: busy=%0b v=%0b want 1 1",
               busy, m_valid);
    end
    @(posedge sclk);
    #3;
    reset_n = 1'b0;
    #1;
    checks += 5;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL s6_valid: got %0b want 0", m_valid);
    end
    if (pop_count !== '0) begin
      errors++;
      $display("FAIL s6_cnt: got %0d want 0", pop_count);
    end
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL s6_busy: got %0b want 0", busy);
    end
    if (q_read_en !== 1'b0) begin
      errors++;
      $display("FAIL s6_rd: got %0b want 0", q_read_en);
    end
    if (m_data !== '0) begin
      errors++;
      $display("FAIL s6_data: got %0h want 0", m_data);
    end
    tick();
    reset_n = 1'b1;
    m_ready = 1'b1;
    push_word(64'h3);
    for (int c = 0; c < 10; c++) begin
      @(negedge sclk);
      if (m_valid && m_ready && !found) begin
        found = 1;
        d0    = m_data;
      end
    end
    checks++;
    if (!found || d0 !== 64'h3) begin
      errors++;
      $display("FAIL s6_after: got f=%0b d=%0h want 1 3",
               found, d0);
    end
    tick();
  endtask

  task automatic test_random();
    int np = 0;
    int cnt0 = model_cnt;
    bit done = 0;
    for (int c = 0; c < 400; c++) begin
      enable  = ($urandom_range(0, 3) != 0);
      m_ready = ($urandom_range(0, 2) != 0);
      push    = (fifo.size() < QD) && ($urandom_range(0, 1) == 1);
      push_data = {$urandom, $urandom};
      if (push) np++;
      tick();
    end
    push    = 1'b0;
    enable  = 1'b1;
    m_ready = 1'b1;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge sclk);
      if (!busy && q_empty) done = 1;
    end
    checks += 2;
    if (!done) begin
      errors++;
      $display("FAIL rnd_drain: busy=%0b empty=%0b want 0 1",
               busy, q_empty);
    end
    if (model_cnt - cnt0 != np) begin
      errors++;
      $display("FAIL rnd_count: got %0d want %0d",
               model_cnt - cnt0, np);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stream();
    test_fill_stall();
    test_toggle();
    test_empty();
    test_enable_gate();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
